// File: rtl/vc_pkg.sv
// Shared types for the drive-command path between the UART receiver,
// the scheduler and the motor executor.
package vc_pkg;

    typedef struct packed {
        logic [7:0] lmotor;
        logic [7:0] rmotor;
        logic [7:0] dur;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        ACK
    } sched_state_t;

    localparam logic [7:0] ACK_CHAR = 8'h41;

endpackage

// File: rtl/cmd_fifo.sv
// Small command FIFO; head is visible combinationally on dout.
module cmd_fifo
    import vc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  cmd_t                     din,
    output cmd_t                     dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    cmd_t          mem_q [DEPTH];
    cmd_t          mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != FULL);
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/drive_scheduler.sv
// Queues drive commands and runs them one at a time through the executor,
// handshaking an ACK after each; stop flushes everything.
module drive_scheduler
    import vc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    input  logic [7:0]             cmd_lmotor,
    input  logic [7:0]             cmd_rmotor,
    input  logic [7:0]             cmd_dur,
    output logic                   cmd_ready,
    output logic                   exec_start,
    output logic [7:0]             lmotor,
    output logic [7:0]             rmotor,
    output logic [7:0]             dur,
    input  logic                   exec_done,
    output logic                   ack_req,
    input  logic                   ack_done,
    input  logic                   stop,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam logic [$clog2(DEPTH):0] FULL = ($clog2(DEPTH) + 1)'(DEPTH);

    sched_state_t state_q, state_d;
    logic [7:0]   lmotor_q, lmotor_d;
    logic [7:0]   rmotor_q, rmotor_d;
    logic [7:0]   dur_q, dur_d;
    logic         exec_start_q, exec_start_d;
    logic         ack_req_q, ack_req_d;
    logic         busy_q, busy_d;
    logic         fifo_push, fifo_pop;
    cmd_t         head;
    cmd_t         din;

    assign cmd_ready = (count != FULL);
    assign fifo_push = cmd_valid && cmd_ready && !stop;
    assign din       = '{lmotor: cmd_lmotor, rmotor: cmd_rmotor, dur: cmd_dur};

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (stop),
        .din   (din),
        .dout  (head),
        .count (count)
    );

    always_comb begin
        state_d  = state_q;
        lmotor_d = lmotor_q;
        rmotor_d = rmotor_q;
        dur_d    = dur_q;
        fifo_pop = 1'b0;
        if (stop) begin
            state_d  = IDLE;
            lmotor_d = '0;
            rmotor_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count != '0) begin
                        fifo_pop = 1'b1;
                        lmotor_d = head.lmotor;
                        rmotor_d = head.rmotor;
                        dur_d    = head.dur;
                        // A zero-duration command is acknowledged without running.
                        state_d  = (head.dur != '0) ? START : ACK;
                    end
                end
                START:   state_d = RUN;
                RUN:     if (exec_done) state_d = ACK;
                ACK:     if (ack_done) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        exec_start_d = (state_d == START);
        ack_req_d    = (state_d == ACK);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lmotor_q     <= '0;
            rmotor_q     <= '0;
            dur_q        <= '0;
            exec_start_q <= 1'b0;
            ack_req_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lmotor_q     <= lmotor_d;
            rmotor_q     <= rmotor_d;
            dur_q        <= dur_d;
            exec_start_q <= exec_start_d;
            ack_req_q    <= ack_req_d;
            busy_q       <= busy_d;
        end
    end

    assign exec_start = exec_start_q;
    assign ack_req    = ack_req_q;
    assign busy       = busy_q;
    assign lmotor     = lmotor_q;
    assign rmotor     = rmotor_q;
    assign dur        = dur_q;

endmodule

// File: tb/tb_drive_scheduler.sv
// Directed bench for drive_scheduler with a queue-based reference model
// compared every cycle, plus hand-computed spot checks.
module tb_drive_scheduler;
    import vc_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_lmotor = '0, cmd_rmotor = '0, cmd_dur = '0;
    logic       exec_done = 1'b0, ack_done = 1'b0, stop = 1'b0;
    logic       cmd_ready, exec_start, ack_req, busy;
    logic [7:0] lmotor, rmotor, dur;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    drive_scheduler #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_lmotor (cmd_lmotor),
        .cmd_rmotor (cmd_rmotor),
        .cmd_dur    (cmd_dur),
        .cmd_ready  (cmd_ready),
        .exec_start (exec_start),
        .lmotor     (lmotor),
        .rmotor     (rmotor),
        .dur        (dur),
        .exec_done  (exec_done),
        .ack_req    (ack_req),
        .ack_done   (ack_done),
        .stop       (stop),
        .busy       (busy),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending commands and the lifecycle flags of
    // the command currently in flight (just launched / executing / awaiting ACK).
    cmd_t       mq[$];
    logic       m_launch = 1'b0, m_exec = 1'b0, m_await = 1'b0;
    logic [7:0] m_l = '0, m_r = '0, m_d = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_launch = 1'b0; m_exec = 1'b0; m_await = 1'b0;
            m_l = '0; m_r = '0; m_d = '0;
        end else if (stop) begin
            mq.delete();
            m_launch = 1'b0; m_exec = 1'b0; m_await = 1'b0;
            m_l = '0; m_r = '0;
        end else begin
            automatic bit   was_full = (mq.size() == DEPTH);
            automatic cmd_t c;
            if (!m_launch && !m_exec && !m_await) begin
                if (mq.size() > 0) begin
                    c = mq.pop_front();
                    m_l = c.lmotor; m_r = c.rmotor; m_d = c.dur;
                    if (c.dur != 0) m_launch = 1'b1;
                    else            m_await  = 1'b1;
                end
            end else if (m_launch) begin
                m_launch = 1'b0; m_exec = 1'b1;
            end else if (m_exec) begin
                if (exec_done) begin m_exec = 1'b0; m_await = 1'b1; end
            end else if (ack_done) begin
                m_await = 1'b0;
            end
            if (cmd_valid && !was_full)
                mq.push_back('{lmotor: cmd_lmotor, rmotor: cmd_rmotor, dur: cmd_dur});
        end
    end

    always @(negedge clk) begin
        check("m_exec_start", exec_start, m_launch);
        check("m_ack_req", ack_req, m_await);
        check("m_busy", busy, m_launch | m_exec | m_await);
        check("m_count", count, mq.size());
        check("m_cmd_ready", cmd_ready, mq.size() != DEPTH);
        check("m_lmotor", lmotor, m_l);
        check("m_rmotor", rmotor, m_r);
        check("m_dur", dur, m_d);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push_cmd(input logic [7:0] l, input logic [7:0] r, input logic [7:0] d);
        cmd_valid = 1'b1; cmd_lmotor = l; cmd_rmotor = r; cmd_dur = d;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!exec_start && n < 40) begin cyc(); n++; end
        check("start_seen", exec_start, 1);
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!ack_req && n < 40) begin cyc(); n++; end
        check("ack_seen", ack_req, 1);
    endtask

    task automatic finish_run();
        repeat (3) cyc();
        exec_done = 1'b1; cyc(); exec_done = 1'b0;
        wait_ack();
        ack_done = 1'b1; cyc(); ack_done = 1'b0;
    endtask

    task automatic serve(input logic [7:0] l, input logic [7:0] r, input logic [7:0] d,
                         input int exp_cnt);
        wait_start();
        check("serve_lmotor", lmotor, l);
        check("serve_rmotor", rmotor, r);
        check("serve_dur", dur, d);
        check("serve_count", count, exp_cnt);
        finish_run();
    endtask

    initial begin
        repeat (2) cyc();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_exec_start", exec_start, 0);
        reset = 1'b0;
        cyc();

        // Single command
        push_cmd(8'h40, 8'hC0, 8'h05);
        check("s1_count", count, 1);
        check("s1_no_start", exec_start, 0);
        cyc();
        check("s1_start", exec_start, 1);
        check("s1_lmotor", lmotor, 8'h40);
        check("s1_rmotor", rmotor, 8'hC0);
        check("s1_dur", dur, 8'h05);
        cyc();
        check("s1_start_gone", exec_start, 0);
        check("s1_busy", busy, 1);
        repeat (20) cyc();
        exec_done = 1'b1; cyc(); exec_done = 1'b0;
        check("s1_ack_req", ack_req, 1);
        ack_done = 1'b1; cyc(); ack_done = 1'b0;
        check("s1_ack_fall", ack_req, 0);
        check("s1_idle", busy, 0);

        // Back-to-back fill while the first command executes
        push_cmd(8'h01, 8'h81, 8'h03);
        cyc();
        push_cmd(8'h02, 8'h82, 8'h04);
        push_cmd(8'h03, 8'h83, 8'h05);
        push_cmd(8'h04, 8'h84, 8'h06);
        push_cmd(8'h05, 8'h85, 8'h07);
        check("b2b_full", count, 4);
        check("b2b_not_ready", cmd_ready, 0);
        push_cmd(8'h06, 8'h86, 8'h08);
        check("b2b_drop", count, 4);
        finish_run();
        serve(8'h02, 8'h82, 8'h04, 3);
        serve(8'h03, 8'h83, 8'h05, 2);
        serve(8'h04, 8'h84, 8'h06, 1);
        serve(8'h05, 8'h85, 8'h07, 0);
        repeat (3) cyc();
        check("b2b_drained", busy, 0);

        // Zero duration
        push_cmd(8'h11, 8'h22, 8'h00);
        cyc();
        check("z_ack", ack_req, 1);
        check("z_no_start", exec_start, 0);
        check("z_lmotor", lmotor, 8'h11);
        check("z_rmotor", rmotor, 8'h22);
        ack_done = 1'b1; cyc(); ack_done = 1'b0;
        check("z_idle", busy, 0);

        // Stop in RUN with two queued
        push_cmd(8'h33, 8'h44, 8'h09);
        cyc();
        push_cmd(8'h55, 8'h66, 8'h07);
        push_cmd(8'h77, 8'h88, 8'h06);
        check("st_count2", count, 2);
        stop = 1'b1; cyc(); stop = 1'b0;
        check("st_idle", busy, 0);
        check("st_count", count, 0);
        check("st_lmotor", lmotor, 0);
        check("st_rmotor", rmotor, 0);
        check("st_dur_held", dur, 8'h09);
        check("st_no_ack", ack_req, 0);
        exec_done = 1'b1; cyc(); exec_done = 1'b0;
        check("st_done_ignored", ack_req, 0);
        cyc();
        check("st_no_start", exec_start, 0);

        // Push and pop in the same cycle at count 2
        push_cmd(8'hA1, 8'h01, 8'h02);
        cyc();
        push_cmd(8'hA2, 8'h02, 8'h02);
        push_cmd(8'hA3, 8'h03, 8'h02);
        exec_done = 1'b1; cyc(); exec_done = 1'b0;
        check("pp_ack", ack_req, 1);
        ack_done = 1'b1; cyc(); ack_done = 1'b0;
        check("pp_pre_count", count, 2);
        push_cmd(8'hA4, 8'h04, 8'h02);
        check("pp_count", count, 2);
        check("pp_start", exec_start, 1);
        check("pp_lmotor", lmotor, 8'hA2);
        finish_run();
        serve(8'hA3, 8'h03, 8'h02, 1);
        serve(8'hA4, 8'h04, 8'h02, 0);
        repeat (2) cyc();

        // Stop coincident with push and ack_done
        push_cmd(8'hB1, 8'h01, 8'h00);
        push_cmd(8'hB2, 8'h02, 8'h05);
        check("sc_in_ack", ack_req, 1);
        check("sc_count1", count, 1);
        stop = 1'b1; ack_done = 1'b1;
        push_cmd(8'hB3, 8'h03, 8'h05);
        stop = 1'b0; ack_done = 1'b0;
        check("sc_count", count, 0);
        check("sc_idle", busy, 0);
        check("sc_no_ack", ack_req, 0);
        repeat (3) cyc();
        check("sc_still_empty", count, 0);
        check("sc_no_start", exec_start, 0);

        // Asynchronous reset in ACK with three queued
        push_cmd(8'hC1, 8'h01, 8'h00);
        push_cmd(8'hC2, 8'h02, 8'h05);
        push_cmd(8'hC3, 8'h03, 8'h05);
        push_cmd(8'hC4, 8'h04, 8'h05);
        check("ar_count3", count, 3);
        check("ar_in_ack", ack_req, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_exec_start", exec_start, 0);
        check("ar_ack_req", ack_req, 0);
        check("ar_busy", busy, 0);
        check("ar_count", count, 0);
        check("ar_cmd_ready", cmd_ready, 1);
        check("ar_lmotor", lmotor, 0);
        check("ar_rmotor", rmotor, 0);
        check("ar_dur", dur, 0);
        repeat (3) cyc();
        check("ar_hold_no_start", exec_start, 0);
        reset = 1'b0;
        repeat (2) cyc();
        check("ar_after_idle", busy, 0);
        check("ar_after_no_start", exec_start, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
